tcp_tx_arbiter: RTL and testbench

Transmit-side counterpart of the TCP receive arbiter. It queues outgoing TCP segment requests from the TCP state machine in a small FIFO. For each queued segment it sequences the MAC, IP and TCP header encoders in order, supplying the IP length and TCP header fields, and reports completion. Sits between the TCP control logic and the MAC/IP/TCP encoder chain.

---
 rtl/tcp.sv | 17 +
 rtl/tcp_tx_arbiter_if.sv | 61 ++++++
 rtl/tcp_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp.sv
// Shared TCP transmit definitions.
// Buffer address width and the queued segment record.
package tcp;

  localparam int BUFF_WIDTH = 16;

  typedef struct packed {
    logic [15:0]           dest_port;
    logic [31:0]           seq;
    logic [31:0]           ack;
    logic [7:0]            flags;
    logic [15:0]           window;
    logic [15:0]           payload_size;
    logic [BUFF_WIDTH-1:0] payload_addr;
  } seg_t;

endpackage

// File: rtl/tcp_tx_arbiter_if.sv
// TCP transmit arbiter bus: request side and encoder chain.
// master = TCP control plus encoders, slave = arbiter.
interface tcp_tx_arbiter_if;

  logic                       req_valid;
  logic                       req_ready;
  logic [15:0]                req_dest_port;
  logic [31:0]                req_sequence_num;
  logic [31:0]                req_ack_num;
  logic [7:0]                 req_flags;
  logic [15:0]                req_window;
  logic [15:0]                req_payload_size;
  logic [tcp::BUFF_WIDTH-1:0] req_payload_addr;

  logic                       mac_encoder_ready;
  logic                       mac_encode_en;
  logic                       mac_encoder_send_next;
  logic                       ip_encode_en;
  logic [15:0]                ip_packet_len;
  logic                       ip_encode_done;
  logic                       tcp_encode_en;
  logic [15:0]                tcp_dest_port;
  logic [31:0]                tcp_sequence_num;
  logic [31:0]                tcp_ack_num;
  logic [7:0]                 tcp_flags;
  logic [15:0]                tcp_window;
  logic [15:0]                tcp_payload_size;
  logic [tcp::BUFF_WIDTH-1:0] tcp_payload_addr;
  logic                       tcp_encode_done;

  logic                       tx_sent;
  logic                       tx_drop;
  logic                       tx_busy;

  modport master (
    output req_valid, req_dest_port, req_sequence_num,
    output req_ack_num, req_flags, req_window,
    output req_payload_size, req_payload_addr,
    output mac_encoder_ready, mac_encoder_send_next,
    output ip_encode_done, tcp_encode_done,
    input  req_ready, mac_encode_en, ip_encode_en,
    input  ip_packet_len, tcp_encode_en,
    input  tcp_dest_port, tcp_sequence_num, tcp_ack_num,
    input  tcp_flags, tcp_window, tcp_payload_size,
    input  tcp_payload_addr, tx_sent, tx_drop, tx_busy
  );

  modport slave (
    input  req_valid, req_dest_port, req_sequence_num,
    input  req_ack_num, req_flags, req_window,
    input  req_payload_size, req_payload_addr,
    input  mac_encoder_ready, mac_encoder_send_next,
    input  ip_encode_done, tcp_encode_done,
    output req_ready, mac_encode_en, ip_encode_en,
    output ip_packet_len, tcp_encode_en,
    output tcp_dest_port, tcp_sequence_num, tcp_ack_num,
    output tcp_flags, tcp_window, tcp_payload_size,
    output tcp_payload_addr, tx_sent, tx_drop, tx_busy
  );

endinterface

// File: rtl/tcp_tx_arbiter.sv
// TCP transmit arbiter: queues segment requests and walks each
// one through the MAC, IP and TCP header encoders in order.
module tcp_tx_arbiter #(
  parameter int DEPTH = 4,
  parameter int MSS   = 1464
) (
  input logic             clk,
  input logic             rst,
  tcp_tx_arbiter_if.slave bus
);

  import tcp::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_IP,
    S_TCP
  } state_t;

  state_t          state;
  state_t          state_nx;
  seg_t            mem [DEPTH];
  seg_t            cur;
  seg_t            req;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            accept;
  logic            oversize;
  logic            push;
  logic            pop;
  logic            ip_go;
  logic            tcp_go;
  logic            sent_go;

  always_comb begin
    req = '{
      dest_port:    bus.req_dest_port,
      seq:          bus.req_sequence_num,
      ack:          bus.req_ack_num,
      flags:        bus.req_flags,
      window:       bus.req_window,
      payload_size: bus.req_payload_size,
      payload_addr: bus.req_payload_addr
    };
  end

  assign bus.req_ready = (count != CW'(DEPTH));
  assign bus.tx_busy   = (state != S_IDLE);

  assign accept   = bus.req_valid && bus.req_ready;
  assign oversize = bus.req_payload_size > 16'(MSS);
  assign push     = accept && !oversize;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    ip_go    = 1'b0;
    tcp_go   = 1'b0;
    sent_go  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0 && bus.mac_encoder_ready) begin
          pop      = 1'b1;
          state_nx = S_MAC;
        end
      end
      S_MAC: begin
        if (bus.mac_encoder_send_next) begin
          ip_go    = 1'b1;
          state_nx = S_IP;
        end
      end
      S_IP: begin
        if (bus.ip_encode_done) begin
          tcp_go   = 1'b1;
          state_nx = S_TCP;
        end
      end
      S_TCP: begin
        if (bus.tcp_encode_done) begin
          sent_go  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur                  <= '0;
      bus.mac_encode_en    <= 1'b0;
      bus.ip_encode_en     <= 1'b0;
      bus.tcp_encode_en    <= 1'b0;
      bus.tx_sent          <= 1'b0;
      bus.tx_drop          <= 1'b0;
      bus.ip_packet_len    <= '0;
      bus.tcp_dest_port    <= '0;
      bus.tcp_sequence_num <= '0;
      bus.tcp_ack_num      <= '0;
      bus.tcp_flags        <= '0;
      bus.tcp_window       <= '0;
      bus.tcp_payload_size <= '0;
      bus.tcp_payload_addr <= '0;
    end else begin
      bus.mac_encode_en <= pop;
      bus.ip_encode_en  <= ip_go;
      bus.tcp_encode_en <= tcp_go;
      bus.tx_sent       <= sent_go;
      bus.tx_drop       <= accept && oversize;
      if (pop) cur <= mem[rd_ptr];
      // 20 B IP header + 20 B TCP header, no options
      if (ip_go) bus.ip_packet_len <= cur.payload_size + 16'd40;
      if (tcp_go) begin
        bus.tcp_dest_port    <= cur.dest_port;
        bus.tcp_sequence_num <= cur.seq;
        bus.tcp_ack_num      <= cur.ack;
        bus.tcp_flags        <= cur.flags;
        bus.tcp_window       <= cur.window;
        bus.tcp_payload_size <= cur.payload_size;
        bus.tcp_payload_addr <= cur.payload_addr;
      end
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_tcp_tx_arbiter;

  import tcp::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tcp_tx_arbiter_if bus();

  tcp_tx_arbiter #(
    .DEPTH(4),
    .MSS  (1464)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [15:0] dest;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] win;
    logic [15:0] size;
    logic [15:0] addr;
    logic [15:0] exp_len;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int s);
    vec_t v;
    v.dest    = 16'(1000 + s);
    v.seq     = 32'(s);
    v.ack     = 32'hA000_0000 | 32'(s);
    v.flags   = 8'h10;
    v.win     = 16'h2000;
    v.size    = 16'(s * 10);
    v.addr    = 16'(16'h0100 * s);
    v.exp_len = 16'(s * 10 + 40);
    return v;
  endfunction

  task automatic drive(vec_t v);
    bus.req_dest_port    = v.dest;
    bus.req_sequence_num = v.seq;
    bus.req_ack_num      = v.ack;
    bus.req_flags        = v.flags;
    bus.req_window       = v.win;
    bus.req_payload_size = v.size;
    bus.req_payload_addr = v.addr;
  endtask

  task automatic push(vec_t v);
    int n;
    n = 0;
    drive(v);
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_accept_in_time", 64'(n < 50), 1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_mac(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.mac_encode_en && n < 50);
    chk("mac_en_seen", bus.mac_encode_en, 1);
  endtask

  task automatic finish_seg(vec_t v);
    bus.mac_encoder_send_next = 1'b1;
    step();
    bus.req_valid             = 1'b0;
    bus.mac_encoder_send_next = 1'b0;
    chk("ip_en", bus.ip_encode_en, 1);
    chk("mac_en_one_cycle", bus.mac_encode_en, 0);
    chk("ip_len", bus.ip_packet_len, v.exp_len);
    bus.ip_encode_done = 1'b1;
    step();
    bus.ip_encode_done = 1'b0;
    chk("tcp_en", bus.tcp_encode_en, 1);
    chk("ip_en_one_cycle", bus.ip_encode_en, 0);
    chk("tcp_dest", bus.tcp_dest_port, v.dest);
    chk("tcp_seq", bus.tcp_sequence_num, v.seq);
    chk("tcp_ack", bus.tcp_ack_num, v.ack);
    chk("tcp_flags", bus.tcp_flags, v.flags);
    chk("tcp_win", bus.tcp_window, v.win);
    chk("tcp_size", bus.tcp_payload_size, v.size);
    chk("tcp_addr", bus.tcp_payload_addr, v.addr);
    bus.tcp_encode_done = 1'b1;
    step();
    bus.tcp_encode_done = 1'b0;
    chk("tx_sent", bus.tx_sent, 1);
    chk("tcp_en_one_cycle", bus.tcp_encode_en, 0);
    chk("busy_idle_at_sent", bus.tx_busy, 0);
    chk("ip_len_hold", bus.ip_packet_len, v.exp_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    vec_t v;
    int   n;
    int   bad;

    tbl[0] = '{16'd80, 32'h1000, 32'h2000, 8'h18,
               16'h4000, 16'd100, 16'h0010, 16'd140};
    tbl[1] = '{16'd443, 32'hFFFF_FFFF, 32'h1, 8'h02,
               16'hFFFF, 16'd0, 16'h0000, 16'd40};
    tbl[2] = '{16'd22, 32'h89AB_CDEF, 32'h1234_5678, 8'h11,
               16'h0100, 16'd1464, 16'hBEEF, 16'd1504};
    tbl[3] = '{16'd8080, 32'h5, 32'h7, 8'h10,
               16'h0200, 16'd1, 16'h0001, 16'd41};

    rst                       = 1'b1;
    bus.req_valid             = 1'b0;
    bus.mac_encoder_ready     = 1'b0;
    bus.mac_encoder_send_next = 1'b0;
    bus.ip_encode_done        = 1'b0;
    bus.tcp_encode_done       = 1'b0;
    drive(mk(0));
    step();
    step();
    rst = 1'b0;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mac_en", bus.mac_encode_en, 0);
    chk("rst_ip_en", bus.ip_encode_en, 0);
    chk("rst_tcp_en", bus.tcp_encode_en, 0);
    chk("rst_tx_sent", bus.tx_sent, 0);
    chk("rst_tx_drop", bus.tx_drop, 0);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_ip_len", bus.ip_packet_len, 0);

    // single segment with exact latency
    bus.mac_encoder_ready = 1'b1;
    push(tbl[0]);
    chk("lat_c1_no_mac", bus.mac_encode_en, 0);
    chk("lat_c1_idle", bus.tx_busy, 0);
    wait_mac(n);
    chk("lat_mac_cycle2", n, 1);
    chk("busy_in_mac", bus.tx_busy, 1);
    finish_seg(tbl[0]);
    step();
    chk("tx_sent_one_pulse", bus.tx_sent, 0);
    chk("busy_after", bus.tx_busy, 0);

    for (int i = 1; i < 4; i++) begin
      push(tbl[i]);
      wait_mac(n);
      finish_seg(tbl[i]);
    end

    // five back-to-back requests into a 4-deep queue
    bus.mac_encoder_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(mk(i));
    chk("full_ready_low", bus.req_ready, 0);
    drive(mk(5));
    bus.req_valid = 1'b1;
    step();
    chk("full_held", bus.req_ready, 0);
    chk("full_no_mac", bus.mac_encode_en, 0);
    bus.mac_encoder_ready = 1'b1;
    chk("pop_no_push_same_cycle", bus.req_ready, 0);
    step();
    chk("pop_mac_en", bus.mac_encode_en, 1);
    chk("ready_after_pop", bus.req_ready, 1);
    finish_seg(mk(1));
    for (int i = 2; i <= 5; i++) begin
      wait_mac(n);
      if (i == 2) chk("min_gap", n, 1);
      finish_seg(mk(i));
    end

    // oversize request is dropped
    v      = tbl[2];
    v.size = 16'd1465;
    push(v);
    chk("drop_pulse", bus.tx_drop, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.mac_encode_en || bus.tx_drop || bus.tx_busy) bad++;
    end
    chk("drop_no_activity", bad, 0);
    chk("drop_ready", bus.req_ready, 1);
    push(tbl[2]);
    wait_mac(n);
    finish_seg(tbl[2]);

    // strobes in the wrong state are ignored
    v = mk(7);
    push(v);
    wait_mac(n);
    bus.ip_encode_done  = 1'b1;
    bus.tcp_encode_done = 1'b1;
    step();
    chk("ooo_no_ip_en", bus.ip_encode_en, 0);
    chk("ooo_no_tcp_en", bus.tcp_encode_en, 0);
    chk("ooo_busy", bus.tx_busy, 1);
    step();
    bus.ip_encode_done  = 1'b0;
    bus.tcp_encode_done = 1'b0;
    chk("ooo_no_tcp_en2", bus.tcp_encode_en, 0);
    chk("ooo_no_sent", bus.tx_sent, 0);
    finish_seg(v);

    // simultaneous push and pop at count 2
    bus.mac_encoder_ready = 1'b0;
    push(mk(11));
    push(mk(12));
    drive(mk(13));
    bus.req_valid         = 1'b1;
    bus.mac_encoder_ready = 1'b1;
    chk("pp_ready", bus.req_ready, 1);
    step();
    bus.req_valid         = 1'b0;
    bus.mac_encoder_ready = 1'b0;
    chk("pp_mac_en", bus.mac_encode_en, 1);
    push(mk(14));
    chk("pp_count3_ready", bus.req_ready, 1);
    push(mk(15));
    chk("pp_count4_full", bus.req_ready, 0);
    bus.mac_encoder_ready = 1'b1;
    finish_seg(mk(11));
    for (int i = 12; i <= 15; i++) begin
      wait_mac(n);
      finish_seg(mk(i));
    end

    // reset while in IP with two segments queued
    bus.mac_encoder_ready = 1'b0;
    push(mk(21));
    push(mk(22));
    push(mk(23));
    bus.mac_encoder_ready = 1'b1;
    wait_mac(n);
    bus.mac_encoder_send_next = 1'b1;
    step();
    bus.mac_encoder_send_next = 1'b0;
    chk("pre_rst_ip_en", bus.ip_encode_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_busy", bus.tx_busy, 0);
    chk("mid_rst_ip_en", bus.ip_encode_en, 0);
    chk("mid_rst_ip_len", bus.ip_packet_len, 0);
    chk("mid_rst_tcp_seq", bus.tcp_sequence_num, 0);
    chk("mid_rst_sent", bus.tx_sent, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.mac_encode_en || bus.tx_sent || bus.tx_drop) bad++;
    end
    chk("mid_rst_queue_flushed", bad, 0);
    push(mk(30));
    wait_mac(n);
    chk("post_rst_latency", n, 1);
    finish_seg(mk(30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
